inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction-fetch stage between the PC register and the decode stage of the simple MIPS core.
- Each cycle it can, it takes the current PC and issues a read on the instruction bus using a req/ack handshake.
- It registers the returned word into the IF/ID output register, and holds the PC via `pc_stall` until the fetch completes.
- It handles decode back-pressure with a one-entry skid buffer, discards fetches killed by a branch flush, and flags misaligned PCs.

Parameters:
- RESET_ADDR, 32'hBFC00000, reset value of `ibus_addr`.
- NOP_INST, 32'h00000000, instruction word driven on bubbles, flushes and misaligned fetches.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc  in  32  current PC from the PC register.
- flush  in  1  branch redirect this cycle; kills all in-flight and buffered fetches.
- id_stall  in  1  decode cannot accept a new instruction.
- pc_stall  out  1  combinational; 1 = PC must hold its value this cycle.
- ibus_req  out  1  instruction bus request, registered.
- ibus_addr  out  32  instruction bus address, registered.
- ibus_ack  in  1  bus completion; `ibus_data` is valid when this is 1.
- ibus_data  in  32  read data.
- id_pc  out  32  PC of the instruction in the IF/ID register.
- id_inst  out  32  instruction word.
- id_valid  out  1  IF/ID register holds a live instruction.
- id_adel  out  1  address-error-on-load flag for `id_pc` (pc[1:0] != 0).

Behaviour:
- **Reset (asynchronous, any state):**
  - state = IDLE, `ibus_req` = 0, `ibus_addr` = RESET_ADDR.
  - `id_pc` = 0, `id_inst` = NOP_INST, `id_valid` = 0, `id_adel` = 0, skid buffer invalid.
  - Reset mid-request drops the request; any later `ibus_ack` for it is ignored.
- **States:** IDLE, REQ, DISCARD, HOLD.
- **Slot free:** `id_valid` = 0 or `id_stall` = 0.
- **Accept:** a fetch result for `pc` completes this cycle and `flush` = 0. `pc_stall` = ~(accept | flush).
- **IDLE** (`ibus_req` = 0):
  - `flush` = 1: stay IDLE.
  - Else `pc[1:0]` != 0 (misaligned): no bus access. Result is {`pc`, NOP_INST, adel = 1}; take the accept path below; next state IDLE.
  - Else: latch `ibus_addr` <= `pc`, `ibus_req` <= 1, go to REQ.
- **REQ** (`ibus_req` = 1; `ibus_addr` stable until ack):
  - ack & flush: drop the data, `ibus_req` <= 0, go to IDLE.
  - !ack & flush: go to DISCARD.
  - ack & !flush & slot free: IF/ID <= {`ibus_addr`, `ibus_data`, adel = 0}, `id_valid` <= 1, `ibus_req` <= 0, go to IDLE.
  - ack & !flush & slot not free: skid buffer <= result, `ibus_req` <= 0, go to HOLD.
  - !ack & !flush: stay in REQ.
- **DISCARD** (`ibus_req` = 1, address unchanged):
  - On ack: drop the data, `ibus_req` <= 0, go to IDLE.
  - Further flushes are ignored.
  - `id_valid` never set from this fetch.
- **HOLD** (`ibus_req` = 0; PC has already advanced; no new fetch is issued):
  - flush: skid buffer invalidated, go to IDLE.
  - Else `id_stall` = 0: IF/ID <= skid buffer, `id_valid` <= 1, go to IDLE.
- **IF/ID register priority (per edge):**
  - flush → `id_valid` <= 0, `id_inst` <= NOP_INST, `id_adel` <= 0.
  - else new load.
  - else `id_stall` = 0 → `id_valid` <= 0, `id_inst` <= NOP_INST (bubble).
  - else hold.
- **Latency and throughput:** IF/ID is valid on the edge of `ibus_ack`. Max throughput is one instruction per 2 cycles with zero-wait ack.
- **Bus rule:** `ibus_req` and `ibus_addr` never change while `ibus_req` = 1 and `ibus_ack` = 0, except under reset.

Test Plan:
1. **Basic fetch:** release reset, `pc` = 0xBFC00000, ack with 0x24080001 one cycle after req → `ibus_addr` = 0xBFC00000; after the ack edge `id_inst` = 0x24080001, `id_pc` = 0xBFC00000, `id_valid` = 1; `pc_stall` = 0 only in the ack cycle.
2. **Back-pressure:** `id_valid` = 1, `id_stall` = 1, ack with 0x8C090004 → state HOLD, `id_inst` unchanged. Drop `id_stall` → next edge `id_inst` = 0x8C090004; no bus req asserted while in HOLD.
3. **Flush during outstanding request:** flush in REQ, ack 3 cycles later with 0xDEADBEEF → `ibus_req` stays 1 with the same address until ack; `id_valid` never 1 for 0xDEADBEEF; `pc_stall` = 0 only in the flush cycle.
4. **Flush coincident with ack:** → data dropped, next state IDLE, `id_valid` = 0.
5. **Misaligned PC:** `pc` = 0xBFC00002 in IDLE → `ibus_req` stays 0; next edge `id_adel` = 1, `id_inst` = 0x00000000, `id_pc` = 0xBFC00002.
6. **Reset mid-request:** assert `rst` in REQ between clock edges → `ibus_req` = 0 and `id_valid` = 0 immediately. A stray `ibus_ack` afterwards → no IF/ID update.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: issues PC reads on a req/ack instruction bus,
// registers the returned word into the IF/ID register, absorbs decode
// back-pressure in a one-entry skid buffer and drops fetches killed by flush.
module inst_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'hBFC00000,
  parameter logic [31:0] NOP_INST   = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        id_stall,
  output logic        pc_stall,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_data,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        id_adel
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        ibus_req_q, ibus_req_d;
  logic [31:0] ibus_addr_q, ibus_addr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic        id_adel_q, id_adel_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic        skid_adel_q, skid_adel_d;

  logic        slot_free;
  logic        accept;
  logic        load;
  logic [31:0] load_pc;
  logic [31:0] load_inst;
  logic        load_adel;

  assign slot_free = ~id_valid_q | ~id_stall;

  // Fetch FSM: decides bus activity, where a completed result goes and whether PC may advance
  always_comb begin
    state_d      = state_q;
    ibus_req_d   = ibus_req_q;
    ibus_addr_d  = ibus_addr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    skid_adel_d  = skid_adel_q;
    accept       = 1'b0;
    load         = 1'b0;
    load_pc      = '0;
    load_inst    = NOP_INST;
    load_adel    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!flush) begin
          if (pc[1:0] != 2'b00) begin
            // Misaligned: the result is produced locally with no bus access
            accept = 1'b1;
            if (slot_free) begin
              load      = 1'b1;
              load_pc   = pc;
              load_inst = NOP_INST;
              load_adel = 1'b1;
            end else begin
              skid_valid_d = 1'b1;
              skid_pc_d    = pc;
              skid_inst_d  = NOP_INST;
              skid_adel_d  = 1'b1;
              state_d      = S_HOLD;
            end
          end else begin
            ibus_addr_d = pc;
            ibus_req_d  = 1'b1;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (flush) begin
          if (ibus_ack) begin
            ibus_req_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            // Bus transaction must still complete; wait it out without using the data
            state_d = S_DISCARD;
          end
        end else if (ibus_ack) begin
          accept     = 1'b1;
          ibus_req_d = 1'b0;
          if (slot_free) begin
            load      = 1'b1;
            load_pc   = ibus_addr_q;
            load_inst = ibus_data;
            load_adel = 1'b0;
            state_d   = S_IDLE;
          end else begin
            skid_valid_d = 1'b1;
            skid_pc_d    = ibus_addr_q;
            skid_inst_d  = ibus_data;
            skid_adel_d  = 1'b0;
            state_d      = S_HOLD;
          end
        end
      end
      S_DISCARD: begin
        if (ibus_ack) begin
          ibus_req_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        if (flush) begin
          skid_valid_d = 1'b0;
          state_d      = S_IDLE;
        end else if (!id_stall) begin
          load         = 1'b1;
          load_pc      = skid_pc_q;
          load_inst    = skid_inst_q;
          load_adel    = skid_adel_q;
          skid_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
    endcase
  end

  // IF/ID register next value: flush beats a new load, which beats a bubble
  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    id_adel_d  = id_adel_q;
    if (flush) begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
      id_adel_d  = 1'b0;
    end else if (load) begin
      id_pc_d    = load_pc;
      id_inst_d  = load_inst;
      id_valid_d = 1'b1;
      id_adel_d  = load_adel;
    end else if (!id_stall) begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end
  end

  // State, bus and IF/ID registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ibus_req_q   <= 1'b0;
      ibus_addr_q  <= RESET_ADDR;
      id_pc_q      <= '0;
      id_inst_q    <= NOP_INST;
      id_valid_q   <= 1'b0;
      id_adel_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= NOP_INST;
      skid_adel_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ibus_req_q   <= ibus_req_d;
      ibus_addr_q  <= ibus_addr_d;
      id_pc_q      <= id_pc_d;
      id_inst_q    <= id_inst_d;
      id_valid_q   <= id_valid_d;
      id_adel_q    <= id_adel_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      skid_adel_q  <= skid_adel_d;
    end
  end

  assign pc_stall  = ~(accept | flush);
  assign ibus_req  = ibus_req_q;
  assign ibus_addr = ibus_addr_q;
  assign id_pc     = id_pc_q;
  assign id_inst   = id_inst_q;
  assign id_valid  = id_valid_q;
  assign id_adel   = id_adel_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: expected IF/ID contents are queued when
// the bus ack (or misaligned PC) is driven and checked when IF/ID loads.
module tb_inst_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } ifid_t;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        flush;
  logic        id_stall;
  logic        pc_stall;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_data;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_adel;

  int unsigned vectors;
  int unsigned miscompares;
  ifid_t       sb[$];
  ifid_t       got;
  ifid_t       exp_e;
  logic [31:0] last_inst;

  inst_fetch #(.RESET_ADDR(32'hBFC00000), .NOP_INST(32'h00000000)) dut (
    .clk(clk), .rst(rst), .pc(pc), .flush(flush), .id_stall(id_stall),
    .pc_stall(pc_stall), .ibus_req(ibus_req), .ibus_addr(ibus_addr),
    .ibus_ack(ibus_ack), .ibus_data(ibus_data), .id_pc(id_pc),
    .id_inst(id_inst), .id_valid(id_valid), .id_adel(id_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    vectors++; if (ibus_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got=%b exp=0", ibus_req); end
    vectors++; if (ibus_addr !== 32'hBFC00000) begin miscompares++; $display("FAIL rst_addr got=%h exp=bfc00000", ibus_addr); end
    vectors++; if (id_pc !== 32'h0) begin miscompares++; $display("FAIL rst_id_pc got=%h exp=0", id_pc); end
    vectors++; if (id_inst !== 32'h0) begin miscompares++; $display("FAIL rst_id_inst got=%h exp=0", id_inst); end
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL rst_id_valid got=%b exp=0", id_valid); end
    vectors++; if (id_adel !== 1'b0) begin miscompares++; $display("FAIL rst_id_adel got=%b exp=0", id_adel); end
    rst = 1'b0;
  endtask

  task automatic test_basic_fetch;
    pc = 32'hBFC00000; flush = 1'b0; id_stall = 1'b0; ibus_ack = 1'b0;
    #1;
    vectors++; if (pc_stall !== 1'b1) begin miscompares++; $display("FAIL basic_stall_idle got=%b exp=1", pc_stall); end
    for (int n = 0; n < 8 && ibus_req !== 1'b1; n++) step();
    vectors++; if (ibus_req !== 1'b1) begin miscompares++; $display("FAIL basic_req_timeout got=%b exp=1", ibus_req); end
    vectors++; if (ibus_addr !== 32'hBFC00000) begin miscompares++; $display("FAIL basic_addr got=%h exp=bfc00000", ibus_addr); end
    vectors++; if (pc_stall !== 1'b1) begin miscompares++; $display("FAIL basic_stall_req got=%b exp=1", pc_stall); end
    ibus_ack = 1'b1; ibus_data = 32'h24080001;
    sb.push_back('{pc: 32'hBFC00000, inst: 32'h24080001, adel: 1'b0});
    #1;
    vectors++; if (pc_stall !== 1'b0) begin miscompares++; $display("FAIL basic_stall_ack got=%b exp=0", pc_stall); end
    step(); ibus_ack = 1'b0;
    vectors++; if (id_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got=%b exp=1", id_valid); end
    got = '{pc: id_pc, inst: id_inst, adel: id_adel};
    exp_e = (sb.size() != 0) ? sb.pop_front() : '0;
    vectors++; if (got !== exp_e) begin miscompares++; $display("FAIL basic_ifid got=%h exp=%h", got, exp_e); end
    vectors++; if (ibus_req !== 1'b0) begin miscompares++; $display("FAIL basic_req_drop got=%b exp=0", ibus_req); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] words [4];
    words[0] = 32'h8C0A0010; words[1] = 32'h014B6020;
    words[2] = 32'hAC0C0014; words[3] = 32'h1000FFFF;
    for (int i = 0; i < 4; i++) begin
      pc = 32'hBFC00004 + 32'(i * 4); id_stall = 1'b0;
      step();
      vectors++; if (ibus_req !== 1'b1 || ibus_addr !== pc) begin miscompares++; $display("FAIL b2b_issue[%0d] got=%b/%h exp=1/%h", i, ibus_req, ibus_addr, pc); end
      vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_bubble[%0d] got=%b exp=0", i, id_valid); end
      ibus_ack = 1'b1; ibus_data = words[i];
      sb.push_back('{pc: pc, inst: words[i], adel: 1'b0});
      step(); ibus_ack = 1'b0;
      got = '{pc: id_pc, inst: id_inst, adel: id_adel};
      exp_e = (sb.size() != 0) ? sb.pop_front() : '0;
      vectors++; if (got !== exp_e || id_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_ifid[%0d] got=%h v=%b exp=%h v=1", i, got, id_valid, exp_e); end
    end
    last_inst = words[3];
  endtask

  task automatic test_backpressure;
    pc = 32'hBFC00100; id_stall = 1'b1;
    step();
    vectors++; if (id_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid got=%b exp=1", id_valid); end
    ibus_ack = 1'b1; ibus_data = 32'h8C090004;
    sb.push_back('{pc: 32'hBFC00100, inst: 32'h8C090004, adel: 1'b0});
    #1;
    vectors++; if (pc_stall !== 1'b0) begin miscompares++; $display("FAIL bp_stall_ack got=%b exp=0", pc_stall); end
    step(); ibus_ack = 1'b0; pc = 32'hBFC00104;
    vectors++; if (id_inst !== last_inst || id_valid !== 1'b1) begin miscompares++; $display("FAIL bp_ifid_held got=%h v=%b exp=%h v=1", id_inst, id_valid, last_inst); end
    vectors++; if (ibus_req !== 1'b0) begin miscompares++; $display("FAIL bp_req_hold1 got=%b exp=0", ibus_req); end
    #1;
    vectors++; if (pc_stall !== 1'b1) begin miscompares++; $display("FAIL bp_stall_hold got=%b exp=1", pc_stall); end
    step();
    vectors++; if (ibus_req !== 1'b0 || id_inst !== last_inst) begin miscompares++; $display("FAIL bp_hold2 got=%b/%h exp=0/%h", ibus_req, id_inst, last_inst); end
    id_stall = 1'b0;
    #1;
    vectors++; if (pc_stall !== 1'b1) begin miscompares++; $display("FAIL bp_stall_release got=%b exp=1", pc_stall); end
    step();
    got = '{pc: id_pc, inst: id_inst, adel: id_adel};
    exp_e = (sb.size() != 0) ? sb.pop_front() : '0;
    vectors++; if (got !== exp_e || id_valid !== 1'b1) begin miscompares++; $display("FAIL bp_ifid got=%h v=%b exp=%h v=1", got, id_valid, exp_e); end
    vectors++; if (ibus_req !== 1'b0) begin miscompares++; $display("FAIL bp_req_release got=%b exp=0", ibus_req); end
  endtask

  task automatic test_flush_outstanding;
    pc = 32'hBFC00200; id_stall = 1'b0;
    step();
    vectors++; if (ibus_req !== 1'b1 || ibus_addr !== 32'hBFC00200) begin miscompares++; $display("FAIL fo_issue got=%b/%h exp=1/bfc00200", ibus_req, ibus_addr); end
    flush = 1'b1;
    #1;
    vectors++; if (pc_stall !== 1'b0) begin miscompares++; $display("FAIL fo_stall_flush got=%b exp=0", pc_stall); end
    step(); flush = 1'b0; pc = 32'hBFC00300;
    #1;
    vectors++; if (ibus_req !== 1'b1 || ibus_addr !== 32'hBFC00200 || pc_stall !== 1'b1) begin miscompares++; $display("FAIL fo_c1 got=%b/%h/%b exp=1/bfc00200/1", ibus_req, ibus_addr, pc_stall); end
    step(); flush = 1'b1;
    step(); flush = 1'b0;
    vectors++; if (ibus_req !== 1'b1 || ibus_addr !== 32'hBFC00200) begin miscompares++; $display("FAIL fo_c3 got=%b/%h exp=1/bfc00200", ibus_req, ibus_addr); end
    ibus_ack = 1'b1; ibus_data = 32'hDEADBEEF;
    #1;
    vectors++; if (pc_stall !== 1'b1) begin miscompares++; $display("FAIL fo_stall_ack got=%b exp=1", pc_stall); end
    step(); ibus_ack = 1'b0;
    vectors++; if (ibus_req !== 1'b0 || id_valid !== 1'b0 || id_inst === 32'hDEADBEEF) begin miscompares++; $display("FAIL fo_dropped got=%b/%b/%h exp=0/0/not-deadbeef", ibus_req, id_valid, id_inst); end
  endtask

  task automatic test_flush_with_ack;
    pc = 32'hBFC00300;
    step();
    vectors++; if (ibus_req !== 1'b1 || ibus_addr !== 32'hBFC00300) begin miscompares++; $display("FAIL fa_issue got=%b/%h exp=1/bfc00300", ibus_req, ibus_addr); end
    ibus_ack = 1'b1; ibus_data = 32'hCAFEF00D; flush = 1'b1;
    #1;
    vectors++; if (pc_stall !== 1'b0) begin miscompares++; $display("FAIL fa_stall got=%b exp=0", pc_stall); end
    step(); ibus_ack = 1'b0; flush = 1'b0;
    vectors++; if (ibus_req !== 1'b0 || id_valid !== 1'b0) begin miscompares++; $display("FAIL fa_dropped got=%b/%b exp=0/0", ibus_req, id_valid); end
    pc = 32'hBFC00400;
    step();
    vectors++; if (ibus_req !== 1'b1 || ibus_addr !== 32'hBFC00400) begin miscompares++; $display("FAIL fa_idle_reissue got=%b/%h exp=1/bfc00400", ibus_req, ibus_addr); end
    ibus_ack = 1'b1; ibus_data = 32'h3C011234;
    sb.push_back('{pc: 32'hBFC00400, inst: 32'h3C011234, adel: 1'b0});
    step(); ibus_ack = 1'b0;
    got = '{pc: id_pc, inst: id_inst, adel: id_adel};
    exp_e = (sb.size() != 0) ? sb.pop_front() : '0;
    vectors++; if (got !== exp_e || id_valid !== 1'b1) begin miscompares++; $display("FAIL fa_recover got=%h v=%b exp=%h v=1", got, id_valid, exp_e); end
  endtask

  task automatic test_misaligned;
    pc = 32'hBFC00002; id_stall = 1'b0;
    sb.push_back('{pc: 32'hBFC00002, inst: 32'h00000000, adel: 1'b1});
    #1;
    vectors++; if (pc_stall !== 1'b0) begin miscompares++; $display("FAIL mis_stall got=%b exp=0", pc_stall); end
    step();
    vectors++; if (ibus_req !== 1'b0) begin miscompares++; $display("FAIL mis_no_req got=%b exp=0", ibus_req); end
    got = '{pc: id_pc, inst: id_inst, adel: id_adel};
    exp_e = (sb.size() != 0) ? sb.pop_front() : '0;
    vectors++; if (got !== exp_e || id_valid !== 1'b1) begin miscompares++; $display("FAIL mis_ifid got=%h v=%b exp=%h v=1", got, id_valid, exp_e); end
  endtask

  task automatic test_reset_mid_request;
    pc = 32'hBFC00500; id_stall = 1'b1;
    step();
    vectors++; if (ibus_req !== 1'b1 || id_valid !== 1'b1) begin miscompares++; $display("FAIL rmr_pre got=%b/%b exp=1/1", ibus_req, id_valid); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (ibus_req !== 1'b0 || id_valid !== 1'b0 || ibus_addr !== 32'hBFC00000) begin miscompares++; $display("FAIL rmr_async got=%b/%b/%h exp=0/0/bfc00000", ibus_req, id_valid, ibus_addr); end
    #2 rst = 1'b0;
    ibus_ack = 1'b1; ibus_data = 32'h12345678; id_stall = 1'b0; pc = 32'hBFC00600;
    step(); ibus_ack = 1'b0;
    vectors++; if (id_valid !== 1'b0 || id_inst === 32'h12345678) begin miscompares++; $display("FAIL rmr_stray_ack got=%b/%h exp=0/not-12345678", id_valid, id_inst); end
    vectors++; if (ibus_req !== 1'b1 || ibus_addr !== 32'hBFC00600) begin miscompares++; $display("FAIL rmr_reissue got=%b/%h exp=1/bfc00600", ibus_req, ibus_addr); end
    ibus_ack = 1'b1; ibus_data = 32'h24420008;
    sb.push_back('{pc: 32'hBFC00600, inst: 32'h24420008, adel: 1'b0});
    step(); ibus_ack = 1'b0;
    got = '{pc: id_pc, inst: id_inst, adel: id_adel};
    exp_e = (sb.size() != 0) ? sb.pop_front() : '0;
    vectors++; if (got !== exp_e || id_valid !== 1'b1) begin miscompares++; $display("FAIL rmr_recover got=%h v=%b exp=%h v=1", got, id_valid, exp_e); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; pc = 32'hBFC00000; flush = 1'b0; id_stall = 1'b0;
    ibus_ack = 1'b0; ibus_data = '0; last_inst = '0;
    step(); step();
    test_reset();
    test_basic_fetch();
    test_back_to_back();
    test_backpressure();
    test_flush_outstanding();
    test_flush_with_ack();
    test_misaligned();
    test_reset_mid_request();
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
